// File: rtl/ptb_word_packer_if.sv
// ---------------------------------------------------------------------------
// ptb_word_packer_if
// Bundles the bit-stream input, the clear strobe and the word-level
// valid/ready output side of ptb_word_packer.
//   i_ptb, i_ptb_valid : serial PTB bit and its single-cycle qualifier
//   i_clear            : synchronous clear of all packer state
//   o_word, o_word_valid, i_word_ready : FIFO head word handshake
//   o_level            : FIFO occupancy (0..DEPTH)
//   o_overflow         : sticky "a completed word was dropped"
//   o_drop_count       : saturating count of dropped words
// Modport slave is the packer's view; master is the surrounding logic's view.
// ---------------------------------------------------------------------------
interface ptb_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              i_ptb;
    logic              i_ptb_valid;
    logic              i_clear;
    logic              i_word_ready;
    logic [WIDTH-1:0]  o_word;
    logic              o_word_valid;
    logic [LVL_W-1:0]  o_level;
    logic              o_overflow;
    logic [CNT_W-1:0]  o_drop_count;

    modport slave (
        input  i_ptb, i_ptb_valid, i_clear, i_word_ready,
        output o_word, o_word_valid, o_level, o_overflow, o_drop_count
    );

    modport master (
        output i_ptb, i_ptb_valid, i_clear, i_word_ready,
        input  o_word, o_word_valid, o_level, o_overflow, o_drop_count
    );
endinterface

// File: rtl/ptb_word_packer.sv
// ---------------------------------------------------------------------------
// ptb_word_packer
// Packs the serial PTB LFSR bit stream MSB-first into WIDTH-bit words and
// buffers them in a DEPTH-entry FIFO presented on a valid/ready handshake.
// Words completing while the FIFO is full (and not being popped) are dropped,
// flagged on a sticky overflow bit and counted in a saturating counter.
// Ports:
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ptb_word_packer_if.slave (bit input, clear, word handshake,
//           level, overflow and drop count)
// ---------------------------------------------------------------------------
module ptb_word_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ptb_word_packer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int BC_W  = $clog2(WIDTH);

    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_sr;
    logic [BC_W-1:0]  r_bitcnt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Shifted value including the current bit; equals the completed word
    // when the counter sits on the last bit position.
    assign w_word     = {r_sr[WIDTH-2:0], bus.i_ptb};
    assign w_complete = bus.i_ptb_valid && (r_bitcnt == LAST_BIT);
    assign w_full     = (r_level == FULL_LVL);

    // Clear suppresses every FIFO side effect in its cycle.
    assign w_pop  = !bus.i_clear && (r_level != '0) && bus.i_word_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = !bus.i_clear && w_complete && (!w_full || w_pop);
    assign w_drop = !bus.i_clear && w_complete && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr       <= '0;
            r_bitcnt   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (bus.i_clear) begin
            r_sr       <= '0;
            r_bitcnt   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (bus.i_ptb_valid) begin
                r_sr     <= w_word;
                r_bitcnt <= w_complete ? '0 : r_bitcnt + 1'b1;
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    // In the full push+pop case wr_ptr == rd_ptr, and overwriting the entry
    // being popped is exactly what is wanted.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    assign bus.o_word       = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.o_word_valid = (r_level != '0);
    assign bus.o_level      = r_level;
    assign bus.o_overflow   = r_overflow;
    assign bus.o_drop_count = r_drop_cnt;
endmodule

// File: doc/ptb_word_packer.md
Name: ptb_word_packer

Overview:
- Consumes the serial pseudo-random bit stream (`i_ptb` qualified by `i_ptb_valid`) from the PTB LFSR stage.
- Packs accepted bits MSB-first into WIDTH-bit words and buffers completed words in a DEPTH-entry FIFO.
- Presents words downstream on a valid/ready handshake; overflow is reported and dropped words are counted.
- Sits directly between the LFSR bit generator and the scaler's word-level consumers.

Parameters:
- WIDTH, 8: bits per packed word; legal values 2..32.
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_ptb  input  1  serial PTB data bit.
- i_ptb_valid  input  1  single-cycle strobe; `i_ptb` is sampled only when this is high.
- i_clear  input  1  synchronous clear of all state; highest priority after reset.
- o_word  output  WIDTH  FIFO head word; 0 when FIFO empty.
- o_word_valid  output  1  high when FIFO non-empty.
- i_word_ready  input  1  downstream accept; pop occurs when `o_word_valid & i_word_ready`.
- o_level  output  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- o_overflow  output  1  sticky: a completed word was dropped.
- o_drop_count  output  CNT_W  number of dropped words; saturates at all-ones.

Behaviour:
- Reset (`rst_n` low, asynchronous) clears:
  - shift register and bit counter;
  - FIFO pointers; `o_level`=0, `o_word_valid`=0, `o_word`=0;
  - `o_overflow`=0, `o_drop_count`=0.
- Packing:
  - On each cycle with `i_ptb_valid`=1, shift `sr <= {sr[WIDTH-2:0], i_ptb}`; bit counter increments 0..WIDTH-1.
  - The first accepted bit therefore ends at MSB.
  - Cycles with `i_ptb_valid`=0 leave the shift register and counter untouched.
- Word completion:
  - Occurs on the accepted bit while counter==WIDTH-1.
  - Completed word = `{sr[WIDTH-2:0], i_ptb}`; counter wraps to 0 in the same cycle.
  - No gap is needed before the next word's first bit.
- Push: the completed word is written at `wr_ptr` on that clock edge.
  - Into an empty FIFO it is visible on `o_word` with `o_word_valid`=1 on the next cycle (latency 1 cycle from the completing sample).
- Pop: when `o_word_valid` & `i_word_ready`, `rd_ptr` advances; the next head, or 0 if empty, appears the following cycle.
  - `i_word_ready` while empty has no effect.
- Full FIFO:
  - If a word completes while full and no pop occurs in the same cycle, the word is dropped.
  - Drop sets `o_overflow`=1 (sticky) and increments `o_drop_count` (holds at 2^CNT_W-1).
  - FIFO contents and pointers are unchanged.
- Simultaneous push and pop:
  - Both take effect; `o_level` is unchanged. This includes the full case: no drop, and the head is replaced by the next entry.
- Level: `o_level` = pushes − pops, updated registered; never exceeds DEPTH; `o_word_valid` = (`o_level` != 0).
- `i_clear`=1 for one cycle:
  - Next cycle, all state equals reset values; partial word bits are discarded.
  - A concurrent `i_ptb_valid` bit is discarded.
  - A concurrent pop is ignored, and `o_word_valid` drops.
- Reset mid-word or mid-handshake: all state is cleared immediately; no partial word survives.
- Pointers wrap modulo DEPTH; full/empty are distinguished by the occupancy counter, not pointer equality.

Test Plan (WIDTH=8, DEPTH=4, CNT_W=8):
- Bit order: reset, then 8 strobes with bits 1,0,1,1,0,0,1,0 and `i_word_ready`=1.
  - One cycle after the 8th strobe: `o_word`=8'hB2, `o_word_valid`=1, `o_level`=1.
  - Next cycle: `o_level`=0, `o_word`=0.
- Sparse strobes: bits every 32 cycles (upstream cadence), pattern 8'hA5.
  - Word completes only on the 8th strobe; counter holds between strobes.
- Overflow: `i_word_ready`=0, push 6 words 8'h01..8'h06.
  - `o_level`=4; `o_overflow`=1 and `o_drop_count`=2 after the 6th word.
  - Pops return 01,02,03,04 in order.
- Push+pop at full: FIFO full, 8th bit of a new word coincides with `i_word_ready`=1.
  - No drop; `o_level` stays 4; new word is last in pop order.
- Clear mid-word: 5 bits in, then `i_clear`; then 8 bits of 8'h3C.
  - `o_word`=8'h3C; `o_overflow`=0; `o_drop_count`=0.
- Async reset: assert `rst_n`=0 mid-clock with FIFO at level 3 and `o_overflow`=1.
  - All outputs return to 0 immediately, without waiting for a clock edge.
